mem_arbiter: RTL and testbench
==============================

# mem_arbiter

- Shares the single SoC memory IO port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one-cycle request pulses from either requester and buffers a losing or late request.
- Issues exactly one outstanding transaction to memory at a time.
- Routes the memory response back to the requester that owns the transaction.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask width is DATA_W/8

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- ifu_reqValid  in  1  IFU request pulse; read only
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_respValid  out  1  IFU response strobe
- ifu_rdata  out  DATA_W  IFU read data
- lsu_reqValid  in  1  LSU request pulse
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte enables
- lsu_respValid  out  1  LSU response strobe; also completes writes
- lsu_rdata  out  DATA_W  LSU read data
- io_reqValid  out  1  memory request pulse, exactly one cycle per transaction
- io_addr  out  ADDR_W  memory address
- io_wen  out  1  write enable
- io_wdata  out  DATA_W  write data
- io_wmask  out  DATA_W/8  write byte enables
- io_respValid  in  1  memory response strobe
- io_rdata  in  DATA_W  memory read data

## Operation
States:
- ARB_IDLE: no transaction outstanding.
- ARB_BUSY_IFU: IFU transaction outstanding.
- ARB_BUSY_LSU: LSU transaction outstanding.

Pending buffers (one per requester):
- Contents: valid bit plus the request fields (addr; for LSU also wen, wdata, wmask).
- Candidate for a requester = its live reqValid OR its pending valid. Pending data wins over live inputs.

ARB_IDLE:
- Candidates present: pick a winner, assert io_reqValid combinationally in the same cycle, and drive io_* from the winner's source.
- Update: pending[winner] cleared, state -> ARB_BUSY_<winner>.
- A loser with a live request is captured into its pending buffer.
- No candidate: io_reqValid=0; io_addr, io_wen, io_wdata, io_wmask = 0.

ARB_BUSY_x:
- Any live request from either requester is captured into that requester's pending buffer.
- io_respValid=1: assert x_respValid for that cycle; state -> ARB_IDLE.
- No new request is issued in the response cycle. A pending request issues on the next cycle.

Response data:
- ifu_rdata = lsu_rdata = io_rdata, unconditionally.
- Only the owner's respValid strobes. The other respValid stays 0.

Protocol and corner cases:
- A requester keeps at most one request in flight.
- A live request while the same requester's pending valid is set, or while it owns the outstanding transaction, is a protocol violation: it is ignored and the buffer is unchanged. Under verilator a simulation assertion flags it.
- io_respValid in ARB_IDLE is ignored; both respValid stay 0.

## Timing
- Request to io_reqValid: 0 cycles, combinational, when the arbiter is idle and the request wins.
- Request to io_reqValid when the arbiter is busy or the request loses: issued the cycle after the outstanding transaction's response.
- io_respValid to x_respValid: 0 cycles, combinational.
- Minimum spacing between consecutive io_reqValid pulses: 2 cycles (request, then response in the next cycle at the earliest).
- Reset asserted: state=ARB_IDLE, both pending valid=0, last-grant=IFU.
- All outputs are forced to 0 while reset_n=0, regardless of inputs.
- Reset asserted mid-transaction: the outstanding transaction is abandoned. A memory response arriving after reset release is ignored as an idle response.

## Configuration
ARB_RR_EN selects how a tie between simultaneous candidates is resolved.
- Defined: round-robin. A tie grants the requester other than last-grant. last-grant updates on every grant.
- Undefined: fixed priority, LSU always wins ties. The last-grant register is not built.
- Non-tie grants are identical in both builds.

## Structure
- Package mem_arb_pkg holds:
  - arb_state_e: ARB_IDLE, ARB_BUSY_IFU, ARB_BUSY_LSU
  - req_id_e: REQ_IFU, REQ_LSU
- Sub-module arb_req_buf: parameterised single-entry holding register (valid + payload) with capture/clear controls. It is instantiated once per requester; the IFU instance carries wen=0 and mask/data tied to 0.
- Under verilator, a debug string register decodes the current state.

## Test plan
- IFU-only read: ifu_reqValid with addr 0x8000_0000 at cycle 0 gives io_reqValid=1 and io_addr=0x8000_0000 at cycle 0. io_respValid with rdata 0x0000_0013 at cycle 3 gives ifu_respValid=1 and ifu_rdata=0x13 at cycle 3; lsu_respValid stays 0.
- Simultaneous requests, fixed priority: IFU 0x100 and LSU write 0x200/0xDEADBEEF/mask 0xF at cycle 0. The LSU write issues at cycle 0; after its response, IFU 0x100 issues from pending on the cycle after.
- Simultaneous requests, ARB_RR_EN: three back-to-back tie rounds grant LSU, IFU, LSU.
- Request during busy: LSU busy, IFU request at 0x104 arrives mid-wait. IFU 0x104 issues exactly one cycle after lsu_respValid.
- Reset mid-transaction: reset_n=0 while ARB_BUSY_IFU with LSU pending. After release, a stray io_respValid produces no respValid and no pending request issues.
- Protocol violation: a second ifu_reqValid while the IFU owns the outstanding transaction is dropped and the assertion fires. Only one io_reqValid is seen for the IFU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the IFU/LSU memory arbiter.
// Holds the arbiter state encoding, the requester identifiers and a small
// helper that maps a requester to the busy state it occupies.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IFU = 2'd1,
        ARB_BUSY_LSU = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_IFU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // Busy state entered when the given requester is granted.
    function automatic arb_state_e busy_state(input req_id_e id);
        return (id == REQ_LSU) ? ARB_BUSY_LSU : ARB_BUSY_IFU;
    endfunction

endpackage

// File: rtl/arb_req_buf.sv
// arb_req_buf: single-entry holding register (valid + payload) for a request
// that could not be issued in the cycle it arrived. Capture takes priority
// over clear; the arbiter never asserts both for the same requester.
module arb_req_buf #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         capture,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // Hold the request until it is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory IO port between the IFU (reads) and the LSU
// (reads/writes). One transaction is outstanding at a time; a request that
// loses arbitration or arrives while busy is parked in a per-requester buffer
// and issued the cycle after the outstanding response.
//
// Handshake: every *_reqValid / io_reqValid / *_respValid is a one-cycle pulse
// with no back-pressure; a requester never has more than one request in flight,
// and io_respValid completes the single outstanding io transaction.
//
// Build option: define ARB_RR_EN for round-robin tie breaking; otherwise the
// LSU wins every tie and no last-grant register exists.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                io_reqValid,
  output logic [ADDR_W-1:0]   io_addr,
  output logic                io_wen,
  output logic [DATA_W-1:0]   io_wdata,
  output logic [DATA_W/8-1:0] io_wmask,
  input  logic                io_respValid,
  input  logic [DATA_W-1:0]   io_rdata,
  output logic [1:0]          dbg_state
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PAY_W  = ADDR_W + 1 + DATA_W + MASK_W;

  arb_state_e       state;
  req_id_e          winner;
  logic             ifu_pend_v, lsu_pend_v;
  logic [PAY_W-1:0] ifu_pend_q, lsu_pend_q;
  logic [PAY_W-1:0] ifu_live_pay, lsu_live_pay;
  logic [PAY_W-1:0] ifu_src, lsu_src, io_pay;
  logic             ifu_cand, lsu_cand;
  logic             tie_to_lsu, issue;
  logic             ifu_cap, lsu_cap, ifu_clr, lsu_clr;
  logic             ifu_viol, lsu_viol;

  // The IFU only reads, so its payload carries wen/data/mask as zero.
  assign ifu_live_pay = {ifu_addr, 1'b0, {DATA_W{1'b0}}, {MASK_W{1'b0}}};
  assign lsu_live_pay = {lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};

  // A parked request always takes precedence over the live inputs.
  assign ifu_cand = ifu_pend_v | ifu_reqValid;
  assign lsu_cand = lsu_pend_v | lsu_reqValid;
  assign ifu_src  = ifu_pend_v ? ifu_pend_q : ifu_live_pay;
  assign lsu_src  = lsu_pend_v ? lsu_pend_q : lsu_live_pay;

`ifdef ARB_RR_EN
  req_id_e last_grant;
  assign tie_to_lsu = (last_grant == REQ_IFU);

  // Remember who was granted last so the next tie goes the other way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= REQ_IFU;
    end else if (issue) begin
      last_grant <= winner;
    end
  end
`else
  assign tie_to_lsu = 1'b1;
`endif

  assign winner = (lsu_cand && (!ifu_cand || tie_to_lsu)) ? REQ_LSU : REQ_IFU;
  assign issue  = (state == ARB_IDLE) && (ifu_cand || lsu_cand);

  // A live request that is neither issued nor illegal gets parked.
  assign ifu_cap = ifu_reqValid && !ifu_pend_v &&
                   ((state == ARB_BUSY_LSU) || (issue && winner == REQ_LSU));
  assign lsu_cap = lsu_reqValid && !lsu_pend_v &&
                   ((state == ARB_BUSY_IFU) || (issue && winner == REQ_IFU));
  assign ifu_clr = issue && (winner == REQ_IFU);
  assign lsu_clr = issue && (winner == REQ_LSU);

  // Second request while one is already parked or outstanding is dropped.
  assign ifu_viol = ifu_reqValid && (ifu_pend_v || state == ARB_BUSY_IFU);
  assign lsu_viol = lsu_reqValid && (lsu_pend_v || state == ARB_BUSY_LSU);

  arb_req_buf #(.W(PAY_W)) u_ifu_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .capture (ifu_cap),
    .clear   (ifu_clr),
    .d       (ifu_live_pay),
    .valid   (ifu_pend_v),
    .q       (ifu_pend_q)
  );

  arb_req_buf #(.W(PAY_W)) u_lsu_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .capture (lsu_cap),
    .clear   (lsu_clr),
    .d       (lsu_live_pay),
    .valid   (lsu_pend_v),
    .q       (lsu_pend_q)
  );

  // Ownership FSM: grant from idle, return to idle on the owner's response.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (issue) state <= busy_state(winner);
        end
        ARB_BUSY_IFU, ARB_BUSY_LSU: begin
          if (io_respValid) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Everything visible to the outside is held at zero during reset.
  assign io_pay        = (reset_n && issue) ? ((winner == REQ_LSU) ? lsu_src : ifu_src) : '0;
  assign {io_addr, io_wen, io_wdata, io_wmask} = io_pay;
  assign io_reqValid   = reset_n && issue;
  assign ifu_respValid = reset_n && io_respValid && (state == ARB_BUSY_IFU);
  assign lsu_respValid = reset_n && io_respValid && (state == ARB_BUSY_LSU);
  assign ifu_rdata     = reset_n ? io_rdata : '0;
  assign lsu_rdata     = reset_n ? io_rdata : '0;
  assign dbg_state     = state;

  string state_str;

  // Human-readable state name for waveforms and messages.
  always_comb begin
    state_str = "IDLE";
    case (state)
      ARB_IDLE:     state_str = "IDLE";
      ARB_BUSY_IFU: state_str = "BUSY_IFU";
      ARB_BUSY_LSU: state_str = "BUSY_LSU";
      default:      state_str = "UNKNOWN";
    endcase
  end

  // Flag a requester issuing a second request before its first completes.
  always @(posedge clock) begin
    if (reset_n) begin
      assert (!(ifu_viol || lsu_viol))
        else $warning("mem_arbiter: protocol violation, request ignored (ifu=%0b lsu=%0b) in state %s",
                      ifu_viol, lsu_viol, state_str);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a request-level
// reference model checked every cycle and literal checks per scenario.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int PW = AW + 1 + DW + MW;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic rst_val = 1'b0;
    always #5 clock = ~clock;

    logic          ifu_reqValid = 1'b0;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_respValid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_reqValid = 1'b0;
    logic [AW-1:0] lsu_addr = '0;
    logic          lsu_wen = 1'b0;
    logic [DW-1:0] lsu_wdata = '0;
    logic [MW-1:0] lsu_wmask = '0;
    logic          lsu_respValid;
    logic [DW-1:0] lsu_rdata;
    logic          io_reqValid;
    logic [AW-1:0] io_addr;
    logic          io_wen;
    logic [DW-1:0] io_wdata;
    logic [MW-1:0] io_wmask;
    logic          io_respValid = 1'b0;
    logic [DW-1:0] io_rdata = '0;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_addr      (ifu_addr),
        .ifu_respValid (ifu_respValid),
        .ifu_rdata     (ifu_rdata),
        .lsu_reqValid  (lsu_reqValid),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_respValid (lsu_respValid),
        .lsu_rdata     (lsu_rdata),
        .io_reqValid   (io_reqValid),
        .io_addr       (io_addr),
        .io_wen        (io_wen),
        .io_wdata      (io_wdata),
        .io_wmask      (io_wmask),
        .io_respValid  (io_respValid),
        .io_rdata      (io_rdata),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    int act_issues = 0;
    int exp_viol = 0;
    logic [PW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Requester 0 = IFU, 1 = LSU. owner < 0 means nothing outstanding.
    int            owner = -1;
    bit            pv[2];
    logic [PW-1:0] pp[2];
    logic [PW-1:0] lp[2];
    bit            live[2];
    int            last_g = 0;
    int            w, l;
    logic [PW-1:0] e_pay;
    logic          e_rv, e_ir, e_lr;
    logic [DW-1:0] e_rd;
    logic [PW-1:0] a_pay;

    always @(negedge clock) begin
        e_pay = '0; e_rv = 1'b0; e_ir = 1'b0; e_lr = 1'b0; e_rd = '0;
        if (!reset_n) begin
            owner = -1; pv[0] = 0; pv[1] = 0; last_g = 0;
        end else begin
            e_rd    = io_rdata;
            live[0] = ifu_reqValid;
            live[1] = lsu_reqValid;
            lp[0]   = {ifu_addr, 1'b0, {DW{1'b0}}, {MW{1'b0}}};
            lp[1]   = {lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
            if (owner < 0) begin
                if ((pv[0] || live[0]) || (pv[1] || live[1])) begin
                    if ((pv[0] || live[0]) && (pv[1] || live[1])) begin
`ifdef ARB_RR_EN
                        w = (last_g == 0) ? 1 : 0;
`else
                        w = 1;
`endif
                    end else begin
                        w = (pv[1] || live[1]) ? 1 : 0;
                    end
                    l = 1 - w;
                    e_pay = pv[w] ? pp[w] : lp[w];
                    if (live[w] && pv[w]) exp_viol++;
                    e_rv = 1'b1;
                    exp_q.push_back(e_pay);
                    owner = w; pv[w] = 0; last_g = w;
                    if (live[l]) begin
                        if (pv[l]) exp_viol++;
                        else begin pv[l] = 1; pp[l] = lp[l]; end
                    end
                end
            end else begin
                for (int r = 0; r < 2; r++) begin
                    if (live[r]) begin
                        if (r == owner || pv[r]) exp_viol++;
                        else begin pv[r] = 1; pp[r] = lp[r]; end
                    end
                end
                if (io_respValid) begin
                    if (owner == 0) e_ir = 1'b1; else e_lr = 1'b1;
                    owner = -1;
                end
            end
        end
        chk("io_reqValid",   64'(io_reqValid),   64'(e_rv));
        chk("io_addr",       64'(io_addr),       64'(e_pay[PW-1 -: AW]));
        chk("io_wen",        64'(io_wen),        64'(e_pay[DW+MW]));
        chk("io_wdata",      64'(io_wdata),      64'(e_pay[MW +: DW]));
        chk("io_wmask",      64'(io_wmask),      64'(e_pay[MW-1:0]));
        chk("ifu_respValid", 64'(ifu_respValid), 64'(e_ir));
        chk("lsu_respValid", 64'(lsu_respValid), 64'(e_lr));
        chk("ifu_rdata",     64'(ifu_rdata),     64'(e_rd));
        chk("lsu_rdata",     64'(lsu_rdata),     64'(e_rd));
        if (io_reqValid === 1'b1) begin
            act_issues++;
            a_pay = {io_addr, io_wen, io_wdata, io_wmask};
            if (exp_q.size() == 0) chk("unexpected issue", 64'd1, 64'd0);
            else chk("issue payload lo", 64'(a_pay), 64'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    // One call = one clock cycle; returns mid-cycle with outputs settled.
    task automatic drive(input logic iv, input logic [AW-1:0] ia,
                         input logic lv, input logic [AW-1:0] la, input logic lw,
                         input logic [DW-1:0] ld, input logic [MW-1:0] lm,
                         input logic rv, input logic [DW-1:0] rd);
        @(posedge clock); #1;
        reset_n = rst_val;
        ifu_reqValid = iv; ifu_addr = ia;
        lsu_reqValid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = ld; lsu_wmask = lm;
        io_respValid = rv; io_rdata = rd;
        @(negedge clock); #1;
    endtask

    task automatic idle();
        drive(0, '0, 0, '0, 0, '0, '0, 0, '0);
    endtask
    task automatic ifu_req(input logic [AW-1:0] a);
        drive(1, a, 0, '0, 0, '0, '0, 0, '0);
    endtask
    task automatic lsu_rd(input logic [AW-1:0] a);
        drive(0, '0, 1, a, 0, '0, '0, 0, '0);
    endtask
    task automatic resp(input logic [DW-1:0] d);
        drive(0, '0, 0, '0, 0, '0, '0, 1, d);
    endtask

    // ---------------- directed scenarios ----------------
    int base;

    initial begin
        // Reset with busy-looking inputs: every output must stay at zero.
        rst_val = 1'b0;
        drive(1, 32'h1234, 1, 32'h5678, 1, 32'hFFFF_FFFF, 4'hF, 1, 32'hFFFF_FFFF);
        drive(1, 32'h1234, 1, 32'h5678, 1, 32'hFFFF_FFFF, 4'hF, 1, 32'hFFFF_FFFF);
        chk("rst io_reqValid", 64'(io_reqValid), 64'd0);
        chk("rst ifu_rdata", 64'(ifu_rdata), 64'd0);
        chk("rst lsu_respValid", 64'(lsu_respValid), 64'd0);
        chk("rst dbg_state", 64'(dbg_state), 64'd0);
        rst_val = 1'b1;
        idle();
        idle();

        // IFU-only read.
        ifu_req(32'h8000_0000);
        chk("t1 io_reqValid", 64'(io_reqValid), 64'd1);
        chk("t1 io_addr", 64'(io_addr), 64'h8000_0000);
        chk("t1 io_wen", 64'(io_wen), 64'd0);
        idle();
        idle();
        resp(32'h0000_0013);
        chk("t1 ifu_respValid", 64'(ifu_respValid), 64'd1);
        chk("t1 ifu_rdata", 64'(ifu_rdata), 64'h13);
        chk("t1 lsu_respValid", 64'(lsu_respValid), 64'd0);
        idle();

        // Simultaneous IFU read and LSU write: LSU first, IFU from pending.
        drive(1, 32'h100, 1, 32'h200, 1, 32'hDEAD_BEEF, 4'hF, 0, '0);
        chk("t2 io_addr", 64'(io_addr), 64'h200);
        chk("t2 io_wen", 64'(io_wen), 64'd1);
        chk("t2 io_wdata", 64'(io_wdata), 64'hDEAD_BEEF);
        chk("t2 io_wmask", 64'(io_wmask), 64'hF);
        idle();
        chk("t2 wait io_reqValid", 64'(io_reqValid), 64'd0);
        resp(32'h0);
        chk("t2 lsu_respValid", 64'(lsu_respValid), 64'd1);
        chk("t2 ifu_respValid", 64'(ifu_respValid), 64'd0);
        chk("t2 resp-cycle io_reqValid", 64'(io_reqValid), 64'd0);
        idle();
        chk("t2 pend io_reqValid", 64'(io_reqValid), 64'd1);
        chk("t2 pend io_addr", 64'(io_addr), 64'h100);
        chk("t2 pend io_wen", 64'(io_wen), 64'd0);
        resp(32'h55);
        chk("t2 ifu_respValid", 64'(ifu_respValid), 64'd1);
        idle();

        // Tie rounds.
        drive(1, 32'h300, 1, 32'h400, 0, '0, '0, 0, '0);
        chk("t3 tie1 io_addr", 64'(io_addr), 64'h400);
        resp(32'h44);
        chk("t3 tie1 lsu_respValid", 64'(lsu_respValid), 64'd1);
        lsu_rd(32'h404);
`ifdef ARB_RR_EN
        chk("t3 tie2 io_addr", 64'(io_addr), 64'h300);
        resp(32'h33);
        chk("t3 tie2 ifu_respValid", 64'(ifu_respValid), 64'd1);
        ifu_req(32'h308);
        chk("t3 tie3 io_addr", 64'(io_addr), 64'h404);
        resp(32'h34);
        chk("t3 tie3 lsu_respValid", 64'(lsu_respValid), 64'd1);
        idle();
        chk("t3 pend io_addr", 64'(io_addr), 64'h308);
        resp(32'h35);
        chk("t3 pend ifu_respValid", 64'(ifu_respValid), 64'd1);
`else
        chk("t3 tie2 io_addr", 64'(io_addr), 64'h404);
        resp(32'h33);
        chk("t3 tie2 lsu_respValid", 64'(lsu_respValid), 64'd1);
        idle();
        chk("t3 pend io_addr", 64'(io_addr), 64'h300);
        resp(32'h35);
        chk("t3 pend ifu_respValid", 64'(ifu_respValid), 64'd1);
`endif
        idle();

        // IFU request arrives while the LSU transaction is outstanding.
        lsu_rd(32'h500);
        chk("t4 io_addr", 64'(io_addr), 64'h500);
        idle();
        ifu_req(32'h104);
        chk("t4 busy io_reqValid", 64'(io_reqValid), 64'd0);
        idle();
        resp(32'h66);
        chk("t4 lsu_respValid", 64'(lsu_respValid), 64'd1);
        chk("t4 resp-cycle io_reqValid", 64'(io_reqValid), 64'd0);
        idle();
        chk("t4 pend io_reqValid", 64'(io_reqValid), 64'd1);
        chk("t4 pend io_addr", 64'(io_addr), 64'h104);
        resp(32'h77);
        chk("t4 ifu_respValid", 64'(ifu_respValid), 64'd1);
        idle();

        // Reset while IFU owns the port and LSU is parked.
        ifu_req(32'h600);
        lsu_rd(32'h700);
        chk("t5 busy io_reqValid", 64'(io_reqValid), 64'd0);
        rst_val = 1'b0;
        resp(32'h99);
        chk("t5 rst ifu_respValid", 64'(ifu_respValid), 64'd0);
        chk("t5 rst ifu_rdata", 64'(ifu_rdata), 64'd0);
        rst_val = 1'b1;
        resp(32'h77);
        chk("t5 stray ifu_respValid", 64'(ifu_respValid), 64'd0);
        chk("t5 stray lsu_respValid", 64'(lsu_respValid), 64'd0);
        chk("t5 stray io_reqValid", 64'(io_reqValid), 64'd0);
        chk("t5 dbg_state", 64'(dbg_state), 64'd0);
        idle();
        chk("t5 no pend io_reqValid", 64'(io_reqValid), 64'd0);
        idle();
        chk("t5 no pend io_reqValid 2", 64'(io_reqValid), 64'd0);

        // Second IFU request while IFU owns the port is dropped.
        base = act_issues;
        ifu_req(32'h800);
        chk("t6 io_addr", 64'(io_addr), 64'h800);
        ifu_req(32'h804);
        chk("t6 dup io_reqValid", 64'(io_reqValid), 64'd0);
        resp(32'h88);
        chk("t6 ifu_respValid", 64'(ifu_respValid), 64'd1);
        chk("t6 ifu_rdata", 64'(ifu_rdata), 64'h88);
        idle();
        chk("t6 after io_reqValid", 64'(io_reqValid), 64'd0);
        idle();
        chk("t6 ifu issue count", 64'(act_issues - base), 64'd1);
        chk("t6 model violations", 64'(exp_viol), 64'd1);

        idle();
        chk("exp_q drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #50000;
        n_err++;
        $display("FAIL watchdog: sequence did not complete by t=%0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
